gol_window: RTL and testbench
=============================

GOL_WINDOW -- requirements
Module: gol_window

Interface
REQ-001: Parameter WIDTH, default 16, number of grid columns (>=3).
REQ-002: Parameter HEIGHT, default 16, number of grid rows (>=3).
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst  input  1  reset, asynchronous, active-high.
REQ-005: in_valid  input  1  in_cell/in_sof valid this cycle.
REQ-006: in_ready  output  1  block accepts input this cycle; transfer occurs when in_valid && in_ready.
REQ-007: in_cell  input  1  current-generation cell state, raster order (row 0 col 0 first).
REQ-008: in_sof  input  1  marks the first cell of a frame.
REQ-009: out_valid  output  1  one neighbourhood window presented this cycle; no backpressure.
REQ-010: out_center  output  1  state of cell (out_y, out_x).
REQ-011: out_a..out_h  output  1 each  neighbours: a=NW, b=N, c=NE, d=W, e=E, f=SW, g=S, h=SE; 8 separate 1-bit ports feeding the downstream pixel-rule stage directly.
REQ-012: out_x  output  clog2(WIDTH)  column of centre cell.
REQ-013: out_y  output  clog2(HEIGHT)  row of centre cell.
REQ-014: out_eof  output  1  high with out_valid for cell (HEIGHT-1, WIDTH-1) only.

Function
REQ-015: Storage: shift window of 2*WIDTH+3 cells (two line buffers plus 3 taps) advanced once per slot; a slot is an accepted input or a FLUSH cycle.
REQ-016: States IDLE, FILL, RUN, FLUSH; in_ready=1 in IDLE/FILL/RUN, 0 in FLUSH.
REQ-017: IDLE: accepted cell with in_sof=1 is slot 0, goes to FILL; accepted cells with in_sof=0 are discarded, no state change.
REQ-018: FILL: slots 0..WIDTH (WIDTH+1 slots) produce no output; after slot WIDTH go to RUN.
REQ-019: RUN: each accepted slot k (k>=WIDTH+1) produces output for cell index k-WIDTH-1; after slot WIDTH*HEIGHT-1 go to FLUSH.
REQ-020: FLUSH: WIDTH+1 consecutive cycles, each shifts in 0 and produces one output; after last go to IDLE.
REQ-021: Latency: output for cell index n asserted on cycle after slot n+WIDTH+1; total outputs per frame exactly WIDTH*HEIGHT, raster order, out_x/out_y match index.
REQ-022: Boundary masking, no wrap-around: x==0 forces a,d,f=0; x==WIDTH-1 forces c,e,h=0; y==0 forces a,b,c=0; y==HEIGHT-1 forces f,g,h=0; corners combine both.
REQ-023: out_* registered; when out_valid=0, out_center, out_a..out_h, out_eof are 0, out_x/out_y hold last value.
REQ-024: in_sof=1 accepted in FILL or RUN aborts current frame: that cell becomes slot 0 of a new frame, state FILL, no further outputs from the aborted frame.
REQ-025: in_sof=1 during FLUSH is not accepted (in_ready=0); upstream holds it until IDLE.
REQ-026: Gaps (in_valid=0) in FILL/RUN stall the window; no output that cycle.

Reset
REQ-027: rst high asynchronously forces state IDLE, slot counters 0, window contents 0, out_valid/out_eof/out_center/out_a..out_h 0, out_x/out_y 0.
REQ-028: in_ready 0 while rst is high; 1 on first cycle after rst deasserts.
REQ-029: rst asserted mid-frame discards frame; next output only after a new in_sof frame.

Verification (WIDTH=HEIGHT=4)
REQ-030: Single live cell at (1,1), 16 contiguous cells -> 16 outputs; cell (0,0) has h=1, (1,1) center=1 all neighbours 0, (2,2) a=1; out_eof only on (3,3).
REQ-031: All-ones frame -> corner (0,0) neighbours e,g,h=1 rest 0; edge (0,1) d,e,f,g,h=1; interior (1,1) all 8 =1.
REQ-032: Gapped input (in_valid toggling every cycle) -> identical output values to contiguous case; in_ready=0 for exactly 5 FLUSH cycles after last cell.
REQ-033: in_sof reasserted at cell index 7 -> no output for old frame beyond those already emitted; new frame yields full 16 outputs.
REQ-034: rst pulsed at RUN slot 10 -> all outputs 0 immediately; cells without in_sof after reset produce no output.

Source files
------------

// File: rtl/gol_window.sv
// gol_window: raster-order Game-of-Life neighbourhood extractor.
// Two line buffers plus three taps present a masked 3x3 window per cell.
`default_nettype none

module gol_window #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_cell,
  input  logic                      in_sof,
  output logic                      out_valid,
  output logic                      out_center,
  output logic                      out_a,
  output logic                      out_b,
  output logic                      out_c,
  output logic                      out_d,
  output logic                      out_e,
  output logic                      out_f,
  output logic                      out_g,
  output logic                      out_h,
  output logic [$clog2(WIDTH)-1:0]  out_x,
  output logic [$clog2(HEIGHT)-1:0] out_y,
  output logic                      out_eof
);

  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = $clog2(HEIGHT);
  localparam int SW   = $clog2(WIDTH * HEIGHT);
  localparam int FW   = $clog2(WIDTH + 1);
  localparam int NWIN = 2 * WIDTH + 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [SW-1:0] C_FILL_END  = SW'(WIDTH);
  localparam logic [SW-1:0] C_RUN_END   = SW'(WIDTH * HEIGHT - 1);
  localparam logic [FW-1:0] C_FLUSH_END = FW'(WIDTH);
  localparam logic [XW-1:0] C_XMAX      = XW'(WIDTH - 1);
  localparam logic [YW-1:0] C_YMAX      = YW'(HEIGHT - 1);

  // Tap positions in the shifted window; index 0 is the newest cell (SE of centre).
  localparam int T_SE = 0;
  localparam int T_S  = 1;
  localparam int T_SW = 2;
  localparam int T_E  = WIDTH;
  localparam int T_C  = WIDTH + 1;
  localparam int T_W  = WIDTH + 2;
  localparam int T_NE = 2 * WIDTH;
  localparam int T_N  = 2 * WIDTH + 1;
  localparam int T_NW = 2 * WIDTH + 2;

  logic [1:0]      r_state;
  logic [SW-1:0]   r_slot;
  logic [FW-1:0]   r_fcnt;
  logic [XW-1:0]   r_cx;
  logic [YW-1:0]   r_cy;
  // The oldest window cell is only ever read as it leaves, so it is never stored.
  logic [NWIN-2:0] r_win;

  logic            r_valid;
  logic            r_center;
  logic [7:0]      r_nb;
  logic [XW-1:0]   r_ox;
  logic [YW-1:0]   r_oy;
  logic            r_eof;

  logic            w_ready;
  logic            w_accept;
  logic            w_flush;
  logic            w_start;
  logic            w_data;
  logic            w_shift;
  logic            w_emit;
  logic [NWIN-1:0] w_win;
  logic            w_x_lo;
  logic            w_x_hi;
  logic            w_y_lo;
  logic            w_y_hi;
  logic [1:0]      w_state_nxt;
  logic [SW-1:0]   w_slot_nxt;
  logic [FW-1:0]   w_fcnt_nxt;
  logic [XW-1:0]   w_cx_nxt;
  logic [YW-1:0]   w_cy_nxt;
  logic [7:0]      w_nb;

  assign w_flush  = (r_state == S_FLUSH);
  assign w_ready  = ~rst & ~w_flush;
  assign w_accept = in_valid & w_ready;
  assign w_start  = w_accept & in_sof;
  assign w_data   = w_accept & ~in_sof & ((r_state == S_FILL) | (r_state == S_RUN));
  assign w_shift  = w_start | w_data | w_flush;
  assign w_emit   = (w_data & (r_state == S_RUN)) | w_flush;
  assign w_win    = {r_win, (w_flush ? 1'b0 : in_cell)};

  assign w_x_lo = (r_cx == '0);
  assign w_x_hi = (r_cx == C_XMAX);
  assign w_y_lo = (r_cy == '0);
  assign w_y_hi = (r_cy == C_YMAX);

  // Neighbour order a..h = NW,N,NE,W,E,SW,S,SE; off-grid neighbours read as dead.
  assign w_nb = {
    w_win[T_NW] & ~w_x_lo & ~w_y_lo,
    w_win[T_N]  & ~w_y_lo,
    w_win[T_NE] & ~w_x_hi & ~w_y_lo,
    w_win[T_W]  & ~w_x_lo,
    w_win[T_E]  & ~w_x_hi,
    w_win[T_SW] & ~w_x_lo & ~w_y_hi,
    w_win[T_S]  & ~w_y_hi,
    w_win[T_SE] & ~w_x_hi & ~w_y_hi
  };

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_fcnt_nxt  = r_fcnt;
    if (w_start) begin
      w_state_nxt = S_FILL;
      w_slot_nxt  = SW'(1);
    end else if (w_data) begin
      w_slot_nxt = r_slot + SW'(1);
      if ((r_state == S_FILL) && (r_slot == C_FILL_END)) begin
        w_state_nxt = S_RUN;
      end
      if ((r_state == S_RUN) && (r_slot == C_RUN_END)) begin
        w_state_nxt = S_FLUSH;
        w_fcnt_nxt  = '0;
      end
    end else if (w_flush) begin
      if (r_fcnt == C_FLUSH_END) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_fcnt_nxt = r_fcnt + FW'(1);
      end
    end
  end

  always_comb begin
    w_cx_nxt = r_cx;
    w_cy_nxt = r_cy;
    if (w_start) begin
      w_cx_nxt = '0;
      w_cy_nxt = '0;
    end else if (w_emit) begin
      if (w_x_hi) begin
        w_cx_nxt = '0;
        w_cy_nxt = w_y_hi ? '0 : r_cy + YW'(1);
      end else begin
        w_cx_nxt = r_cx + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_slot  <= '0;
      r_fcnt  <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_win   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_cx    <= w_cx_nxt;
      r_cy    <= w_cy_nxt;
      if (w_shift) begin
        r_win <= w_win[NWIN-2:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_center <= 1'b0;
      r_nb     <= '0;
      r_ox     <= '0;
      r_oy     <= '0;
      r_eof    <= 1'b0;
    end else if (w_emit) begin
      r_valid  <= 1'b1;
      r_center <= w_win[T_C];
      r_nb     <= w_nb;
      r_ox     <= r_cx;
      r_oy     <= r_cy;
      r_eof    <= w_x_hi & w_y_hi;
    end else begin
      r_valid  <= 1'b0;
      r_center <= 1'b0;
      r_nb     <= '0;
      r_eof    <= 1'b0;
    end
  end

  assign in_ready   = w_ready;
  assign out_valid  = r_valid;
  assign out_center = r_center;
  assign out_a      = r_nb[7];
  assign out_b      = r_nb[6];
  assign out_c      = r_nb[5];
  assign out_d      = r_nb[4];
  assign out_e      = r_nb[3];
  assign out_f      = r_nb[2];
  assign out_g      = r_nb[1];
  assign out_h      = r_nb[0];
  assign out_x      = r_ox;
  assign out_y      = r_oy;
  assign out_eof    = r_eof;

endmodule

`default_nettype wire

// File: tb/tb_gol_window.sv
// tb_gol_window: randomized and directed checks of gol_window against a grid-level model.
`default_nettype none

module tb_gol_window;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_cell, in_sof;
  logic       in_ready;
  logic       out_valid, out_center, out_eof;
  logic       out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
  logic [1:0] out_x, out_y;

  int checks = 0;
  int errors = 0;

  gol_window #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cell(in_cell), .in_sof(in_sof),
    .out_valid(out_valid), .out_center(out_center),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
    .out_e(out_e), .out_f(out_f), .out_g(out_g), .out_h(out_h),
    .out_x(out_x), .out_y(out_y), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  // Grid-level model: cells of the current frame, slot count, flush countdown.
  bit         g [0:N-1];
  int         m_slot, m_frem;
  bit         m_active, m_flush;
  logic       e_valid, e_eof;
  logic [8:0] e_win;
  logic [1:0] e_x, e_y;

  function automatic bit nb(input int x, input int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return 1'b0;
    return g[y * W + x];
  endfunction

  task automatic emit(input int n);
    int x, y;
    x = n % W;
    y = n / W;
    e_valid = 1'b1;
    e_win = {g[n], nb(x-1, y-1), nb(x, y-1), nb(x+1, y-1), nb(x-1, y), nb(x+1, y),
             nb(x-1, y+1), nb(x, y+1), nb(x+1, y+1)};
    e_eof = (n == N - 1);
    e_x = x[1:0];
    e_y = y[1:0];
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_flush = 0; m_slot = 0; m_frem = 0;
      e_valid = 0; e_win = '0; e_eof = 0; e_x = '0; e_y = '0;
    end else begin
      e_valid = 0; e_win = '0; e_eof = 0;
      if (m_flush) begin
        emit(m_slot - W - 1);
        m_slot++;
        m_frem--;
        if (m_frem == 0) begin m_flush = 0; m_active = 0; end
      end else if (in_valid) begin
        if (in_sof) begin
          m_active = 1; g[0] = in_cell; m_slot = 1;
        end else if (m_active) begin
          g[m_slot] = in_cell;
          if (m_slot >= W + 1) emit(m_slot - W - 1);
          m_slot++;
          if (m_slot == N) begin m_flush = 1; m_frem = W + 1; end
        end
      end
    end
  end

  // Per-cycle compare plus a log of what the DUT emitted.
  logic [8:0] dlog [0:N-1];
  logic [8:0] saved [0:N-1];
  int out_cnt, eof_cnt, eof_idx, low_cnt;
  logic [15:0] act_v, exp_v;

  always @(negedge clk) begin
    if (!rst) begin
      act_v = {out_valid, out_center, out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h,
               out_eof, out_x, out_y, in_ready};
      exp_v = {e_valid, e_win, e_eof, e_x, e_y, ~m_flush};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle t=%0t actual=%b required=%b", $time, act_v, exp_v);
      end
      if (!in_ready) low_cnt++;
      if (out_valid) begin
        dlog[int'(out_y) * W + int'(out_x)] = {out_center, out_a, out_b, out_c, out_d,
                                               out_e, out_f, out_g, out_h};
        out_cnt++;
        if (out_eof) begin eof_cnt++; eof_idx = int'(out_y) * W + int'(out_x); end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    out_cnt = 0; eof_cnt = 0; eof_idx = -1; low_cnt = 0;
    for (int i = 0; i < N; i++) dlog[i] = '0;
  endtask

  task automatic tick(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send(input bit c, input bit s);
    int guard;
    bit rdy;
    guard = 0;
    in_valid = 1'b1; in_cell = c; in_sof = s;
    forever begin
      rdy = in_ready;
      @(posedge clk); #2;
      if (rdy) break;
      guard++;
      if (guard > 200) begin
        errors++;
        $display("FAIL send_timeout actual=%0d required=<200", guard);
        break;
      end
    end
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic frame_single(input bit gapped);
    for (int i = 0; i < N; i++) begin
      send(i == 5, i == 0);
      if (gapped) tick(1);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_cell = 1'b0; in_sof = 1'b0;
    clear_log();
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", {out_valid, out_center, out_a, out_b, out_c, out_d, out_e, out_f,
                          out_g, out_h, out_eof, out_x, out_y}, 0);
    chk("reset_ready_low", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", in_ready, 1);
    tick(2);

    // Single live cell at (1,1), contiguous.
    clear_log();
    frame_single(1'b0);
    tick(8);
    chk("single_count", out_cnt, 16);
    chk("single_00_h", dlog[0], 9'b0_0000_0001);
    chk("single_11_center", dlog[5], 9'b1_0000_0000);
    chk("single_22_a", dlog[10], 9'b0_1000_0000);
    chk("single_eof_count", eof_cnt, 1);
    chk("single_eof_idx", eof_idx, 15);
    for (int i = 0; i < N; i++) saved[i] = dlog[i];

    // All-ones frame.
    clear_log();
    for (int i = 0; i < N; i++) send(1'b1, i == 0);
    tick(8);
    chk("ones_count", out_cnt, 16);
    chk("ones_corner_00", dlog[0], 9'b1_0000_1011);
    chk("ones_edge_01", dlog[1], 9'b1_0001_1111);
    chk("ones_interior_11", dlog[5], 9'b1_1111_1111);

    // Gapped single-cell frame must match the contiguous result.
    clear_log();
    frame_single(1'b1);
    tick(8);
    chk("gapped_count", out_cnt, 16);
    chk("gapped_ready_low", low_cnt, 5);
    for (int i = 0; i < N; i++) chk("gapped_same", dlog[i], saved[i]);

    // Abort at cell index 7: two old outputs, then a full new frame.
    clear_log();
    for (int i = 0; i < 7; i++) send(1'($urandom), i == 0);
    for (int i = 0; i < N; i++) send(1'($urandom), i == 0);
    tick(8);
    chk("abort_count", out_cnt, 18);
    chk("abort_eof_count", eof_cnt, 1);

    // Reset mid-RUN.
    for (int i = 0; i < 11; i++) send(1'($urandom), i == 0);
    rst = 1'b1;
    #1;
    chk("midrun_reset_outputs", {out_valid, out_center, out_a, out_b, out_c, out_d, out_e,
                                 out_f, out_g, out_h, out_eof, out_x, out_y}, 0);
    chk("midrun_reset_ready", in_ready, 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    clear_log();
    for (int i = 0; i < 20; i++) send(1'($urandom), 1'b0);
    tick(8);
    chk("post_reset_no_sof", out_cnt, 0);

    // Randomized frames: noise, gaps, one abort, back-to-back starts.
    for (int f = 0; f < 8; f++) begin
      int len;
      repeat ($urandom_range(0, 3)) send(1'($urandom), 1'b0);
      len = (f == 3) ? int'($urandom_range(1, N - 1)) : N;
      for (int i = 0; i < len; i++) begin
        send(1'($urandom), i == 0);
        if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 3));
      end
      if (f % 2 == 0) tick($urandom_range(0, 6));
    end
    tick(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
